// File: rtl/maheredia_arbiter_pkg.sv
// Shared constants for the button conditioner: debounce default, idle level,
// channel indices.
package maheredia_arbiter_pkg;

   localparam int   DB_CYCLES_DEF = 16;
   localparam int   CNT_W_DEF     = 8;
   localparam logic BTN_IDLE      = 1'b1;
   localparam int   P1            = 0;
   localparam int   P2            = 1;
   localparam int   NUM_CH        = 2;

   // Smallest counter width that can hold a count of n (used as a sanity helper).
   function automatic int cnt_bits(input int n);
      int b;
      b = 1;
      while ((1 << b) <= n) b++;
      return b;
   endfunction

endpackage

// File: rtl/maheredia_debounce.sv
// One button channel: 2-flop synchronizer, run-length debounce counter,
// debounced state and a registered single-cycle press pulse on 1->0.
module maheredia_debounce
   import maheredia_arbiter_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF,
   parameter int CNT_W     = CNT_W_DEF
)(
   input  logic clk,
   input  logic rst_in_n,
   input  logic i_btn,
   output logic o_press,
   output logic o_state
);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_state;
   logic             r_state_d;
   logic             r_press;
   logic [CNT_W-1:0] r_cnt;

   // Bring the asynchronous button into the clock domain; idle level on reset.
   always_ff @(posedge clk or negedge rst_in_n) begin
      if (!rst_in_n) begin
         r_sync1 <= BTN_IDLE;
         r_sync2 <= BTN_IDLE;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
      end
   end

   // Count consecutive disagreeing cycles; any agreeing cycle restarts from 0.
   // The count never passes DB_CYCLES-1: the next disagreeing cycle flips state.
   always_ff @(posedge clk or negedge rst_in_n) begin
      if (!rst_in_n) begin
         r_state <= BTN_IDLE;
         r_cnt   <= '0;
      end else if (r_sync2 == r_state) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
         r_state <= r_sync2;
         r_cnt   <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Pulse one cycle after the debounced state falls; releases are silent.
   always_ff @(posedge clk or negedge rst_in_n) begin
      if (!rst_in_n) begin
         r_state_d <= BTN_IDLE;
         r_press   <= 1'b0;
      end else begin
         r_state_d <= r_state;
         r_press   <= r_state_d & ~r_state;
      end
   end

   assign o_press = r_press;
   assign o_state = r_state;

endmodule

// File: rtl/maheredia_btn_conditioner.sv
// Two-player button conditioner: per-channel debounce, registered active-high
// held levels and optional tie detection.
// Optional feature: define BTN_TIE_DETECT_EN to build the tie pulse; when
// undefined, tie_out is tied to 0.
module maheredia_btn_conditioner
   import maheredia_arbiter_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF,
   parameter int CNT_W     = CNT_W_DEF
)(
   input  logic       clk,
   input  logic       rst_in_n,
   input  logic       req1_in,
   input  logic       req2_in,
   output logic       press1_out,
   output logic       press2_out,
   output logic [1:0] held_out,
   output logic       tie_out
);

   logic [NUM_CH-1:0] w_req;
   logic [NUM_CH-1:0] w_press;
   logic [NUM_CH-1:0] w_state;
   logic [NUM_CH-1:0] r_held;

   assign w_req[P1] = req1_in;
   assign w_req[P2] = req2_in;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      maheredia_debounce #(
         .DB_CYCLES (DB_CYCLES),
         .CNT_W     (CNT_W)
      ) u_db (
         .clk      (clk),
         .rst_in_n (rst_in_n),
         .i_btn    (w_req[g]),
         .o_press  (w_press[g]),
         .o_state  (w_state[g])
      );
   end

   // Held level tracks the inverted debounced state one cycle later, so it
   // moves on the same edge as the press pulse.
   always_ff @(posedge clk or negedge rst_in_n) begin
      if (!rst_in_n) r_held <= '0;
      else           r_held <= ~w_state;
   end

   assign press1_out = w_press[P1];
   assign press2_out = w_press[P2];
   assign held_out   = r_held;

`ifdef BTN_TIE_DETECT_EN
   // Both pulses are registered, so their AND is glitch-free and coincident.
   assign tie_out = w_press[P1] & w_press[P2];
`else
   assign tie_out = 1'b0;
`endif

endmodule

// File: tb/tb_maheredia_btn_conditioner.sv
// Self-checking bench for maheredia_btn_conditioner (default DB_CYCLES=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_maheredia_btn_conditioner;

   localparam int DB  = 16;
   localparam int LAT = DB + 3;   // edge index of the press pulse, first sampling edge = 1

   logic       clk = 1'b0;
   logic       rst_in_n = 1'b0;
   logic       req1_in = 1'b1;
   logic       req2_in = 1'b1;
   logic       press1_out, press2_out, tie_out;
   logic [1:0] held_out;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   maheredia_btn_conditioner dut (
      .clk        (clk),
      .rst_in_n   (rst_in_n),
      .req1_in    (req1_in),
      .req2_in    (req2_in),
      .press1_out (press1_out),
      .press2_out (press2_out),
      .held_out   (held_out),
      .tie_out    (tie_out)
   );

   // Reference model: a channel's debounced state flips once the last DB
   // synchronized samples (raw samples two edges old and older) all disagree
   // with it. Outputs appear one edge after the flip.
   logic [DB:0] m_h1, m_h2;
   logic        m_st1, m_st2, m_pend1, m_pend2;
   logic        e_p1, e_p2;
   logic [1:0]  e_held;

   function automatic logic qual(input logic [DB:0] h, input logic st);
      logic [DB-1:0] w;
      w = h[DB:1];
      return st ? (w == '0) : (w == '1);
   endfunction

   always @(posedge clk or negedge rst_in_n) begin
      if (!rst_in_n) begin
         m_h1 <= '1; m_h2 <= '1;
         m_st1 <= 1'b1; m_st2 <= 1'b1;
         m_pend1 <= 1'b0; m_pend2 <= 1'b0;
         e_p1 <= 1'b0; e_p2 <= 1'b0; e_held <= 2'b00;
      end else begin
         e_p1   <= m_pend1;
         e_p2   <= m_pend2;
         e_held <= {~m_st2, ~m_st1};
         m_pend1 <= qual(m_h1, m_st1) & m_st1;
         m_pend2 <= qual(m_h2, m_st2) & m_st2;
         if (qual(m_h1, m_st1)) m_st1 <= ~m_st1;
         if (qual(m_h2, m_st2)) m_st2 <= ~m_st2;
         m_h1 <= {m_h1[DB-1:0], req1_in};
         m_h2 <= {m_h2[DB-1:0], req2_in};
      end
   end

   task automatic do_reset(input logic r1, input logic r2);
      @(negedge clk);
      rst_in_n = 1'b0;
      req1_in  = r1;
      req2_in  = r2;
      repeat (3) @(negedge clk);
      rst_in_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset(1'b1, 1'b1);
      n_chk++;
      if ({press1_out, press2_out, held_out, tie_out} !== 5'b0)
         $display("FAIL reset_state got %b want 00000", {press1_out, press2_out, held_out, tie_out});
      else n_pass++;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         n_chk++;
         if ({press1_out, press2_out, held_out, tie_out} !== 5'b0)
            $display("FAIL idle_outputs cyc=%0d got %b want 00000", c, {press1_out, press2_out, held_out, tie_out});
         else n_pass++;
      end
   endtask

   task automatic test_single_press();
      do_reset(1'b1, 1'b1);
      req1_in = 1'b0;
      for (int e = 1; e <= 40; e++) begin
         @(negedge clk);
         n_chk++;
         if (press1_out !== (e == LAT) || press2_out !== 1'b0)
            $display("FAIL single_press e=%0d got p1=%b p2=%b want p1=%b p2=0", e, press1_out, press2_out, (e == LAT));
         else n_pass++;
         n_chk++;
         if (held_out !== ((e >= LAT) ? 2'b01 : 2'b00))
            $display("FAIL single_held e=%0d got %b want %b", e, held_out, (e >= LAT) ? 2'b01 : 2'b00);
         else n_pass++;
      end
      // Release: held falls after the same latency, with no pulse.
      req1_in = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         @(negedge clk);
         n_chk++;
         if (press1_out !== 1'b0 || held_out !== ((e >= LAT) ? 2'b00 : 2'b01))
            $display("FAIL release e=%0d got p1=%b held=%b want p1=0 held=%b", e, press1_out, held_out, (e >= LAT) ? 2'b00 : 2'b01);
         else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      do_reset(1'b1, 1'b1);
      req1_in = 1'b0;
      req2_in = 1'b0;
      repeat (LAT + 2) @(negedge clk);
      #2 rst_in_n = 1'b0;
      #1;
      n_chk++;
      if ({press1_out, press2_out, held_out, tie_out} !== 5'b0)
         $display("FAIL async_reset got %b want 00000", {press1_out, press2_out, held_out, tie_out});
      else n_pass++;
      // Inputs stay low through reset release: press follows from the idle sync state.
      @(negedge clk);
      rst_in_n = 1'b1;
      for (int e = 1; e <= 25; e++) begin
         @(negedge clk);
         n_chk++;
         if (press1_out !== (e == LAT) || press2_out !== (e == LAT))
            $display("FAIL press_thru_reset e=%0d got p1=%b p2=%b want %b", e, press1_out, press2_out, (e == LAT));
         else n_pass++;
      end
   endtask

   task automatic test_bounce();
      do_reset(1'b1, 1'b1);
      for (int c = 0; c < 40; c++) begin
         req2_in = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
         @(negedge clk);
         n_chk++;
         if (press2_out !== 1'b0 || held_out !== 2'b00)
            $display("FAIL bounce c=%0d got p2=%b held=%b want p2=0 held=00", c, press2_out, held_out);
         else n_pass++;
      end
      req2_in = 1'b0;
      for (int e = 1; e <= 30; e++) begin
         @(negedge clk);
         n_chk++;
         if (press2_out !== (e == LAT) || press1_out !== 1'b0)
            $display("FAIL bounce_settle e=%0d got p2=%b p1=%b want p2=%b p1=0", e, press2_out, press1_out, (e == LAT));
         else n_pass++;
      end
   endtask

   task automatic test_tie();
      logic tie_exp;
      do_reset(1'b1, 1'b1);
      req1_in = 1'b0;
      req2_in = 1'b0;
      for (int e = 1; e <= 25; e++) begin
         @(negedge clk);
`ifdef BTN_TIE_DETECT_EN
         tie_exp = (e == LAT);
`else
         tie_exp = 1'b0;
`endif
         n_chk++;
         if (press1_out !== (e == LAT) || press2_out !== (e == LAT) || tie_out !== tie_exp)
            $display("FAIL tie e=%0d got p1=%b p2=%b tie=%b want p=%b tie=%b", e, press1_out, press2_out, tie_out, (e == LAT), tie_exp);
         else n_pass++;
      end
      n_chk++;
      if (held_out !== 2'b11) $display("FAIL tie_held got %b want 11", held_out);
      else n_pass++;
   endtask

   task automatic test_hold_repress();
      int  pulses;
      bit  saw_release;
      do_reset(1'b1, 1'b1);
      pulses = 0;
      saw_release = 0;
      req1_in = 1'b0;
      repeat (200) begin
         @(negedge clk);
         if (press1_out === 1'b1) pulses++;
      end
      n_chk++;
      if (pulses !== 1) $display("FAIL hold_pulses got %0d want 1", pulses);
      else n_pass++;
      req1_in = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (press1_out === 1'b1) pulses++;
         if (held_out[0] === 1'b0) saw_release = 1;
      end
      n_chk++;
      if (!saw_release || pulses !== 1)
         $display("FAIL hold_release got released=%0d pulses=%0d want 1/1", saw_release, pulses);
      else n_pass++;
      req1_in = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (press1_out === 1'b1) pulses++;
      end
      n_chk++;
      if (pulses !== 2) $display("FAIL repress_pulses got %0d want 2", pulses);
      else n_pass++;
   endtask

   task automatic test_reset_midcount();
      do_reset(1'b1, 1'b1);
      req1_in = 1'b0;
      repeat (12) @(negedge clk);   // counter has reached 10 here
      rst_in_n = 1'b0;
      req1_in  = 1'b1;
      @(negedge clk);
      rst_in_n = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         @(negedge clk);
         n_chk++;
         if (press1_out !== 1'b0 || held_out !== 2'b00)
            $display("FAIL reset_midcount e=%0d got p1=%b held=%b want 0/00", e, press1_out, held_out);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      int  len1, len2;
      logic tie_exp;
      do_reset(1'b1, 1'b1);
      len1 = 0;
      len2 = 0;
      for (int c = 0; c < 3000; c++) begin
         if (len1 == 0) begin req1_in = 1'($urandom_range(0, 1)); len1 = $urandom_range(1, 40); end
         if (len2 == 0) begin req2_in = 1'($urandom_range(0, 1)); len2 = $urandom_range(1, 40); end
         len1--;
         len2--;
         @(negedge clk);
`ifdef BTN_TIE_DETECT_EN
         tie_exp = e_p1 & e_p2;
`else
         tie_exp = 1'b0;
`endif
         n_chk++;
         if (press1_out !== e_p1 || press2_out !== e_p2 || held_out !== e_held || tie_out !== tie_exp)
            $display("FAIL random c=%0d got p1=%b p2=%b held=%b tie=%b want p1=%b p2=%b held=%b tie=%b",
                     c, press1_out, press2_out, held_out, tie_out, e_p1, e_p2, e_held, tie_exp);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_async_reset();
      test_bounce();
      test_tie();
      test_hold_repress();
      test_reset_midcount();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
